// File: rtl/eq_pkg.sv
// Shared equalizer constants and queue FSM state type.
// Used by the sample queue and the FIR/ROM blocks.
package eq_pkg;

  localparam int TAPS  = 1021;
  localparam int DEPTH = 1536;

  typedef enum logic [1:0] {
    IDLE,
    SEQ,
    GAP
  } queue_state_t;

endpackage

// File: rtl/dp_ram_16x2.sv
// Simple dual-port stereo sample RAM, DEPTH x {lft,rght}.
// One write port, one read port with 1-cycle read latency.
module dp_ram_16x2 #(
  parameter int DEPTH = 1536,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [15:0]   wl,
  input  logic [15:0]   wr,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [15:0]   rl,
  output logic [15:0]   rr
);

  logic [31:0] mem [DEPTH];
  logic [31:0] q;

  // store the incoming pair
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= {wl, wr};
  end

  // registered read
  always_ff @(posedge clk) begin
    if (re) q <= mem[ra];
  end

  assign rl = q[31:16];
  assign rr = q[15:0];

endmodule

// File: rtl/stereo_sample_queue.sv
// Stereo circular sample buffer feeding the FIR band filters.
// Replays the newest TAPS pairs oldest-first after each write.
module stereo_sample_queue #(
  parameter int DEPTH = eq_pkg::DEPTH,
  parameter int TAPS  = eq_pkg::TAPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  output logic        sequencing,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out
);

  import eq_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
  localparam logic [AW-1:0] END_A  = AW'(TAPS + 1);
  localparam logic [AW-1:0] BACK_A = AW'(DEPTH - TAPS);
  localparam logic [AW:0]   DEP_W  = (AW+1)'(DEPTH);

  queue_state_t  state;
  logic [AW-1:0] new_ptr;
  logic [AW-1:0] fill_cnt;
  logic [AW-1:0] fill_nxt;
  logic [AW-1:0] start;
  logic [AW-1:0] start_calc;
  logic [AW-1:0] cnt;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_sum;
  logic          pending;
  logic          trigger;
  logic          rd_en;
  logic          out_en;
  logic [15:0]   q_l;
  logic [15:0]   q_r;

  assign fill_nxt = (fill_cnt == TAPS_A) ? fill_cnt : fill_cnt + 1'b1;
  assign trigger  = wrt_smpl && (fill_nxt == TAPS_A);

  assign start_calc = (new_ptr >= TAPS_A) ? new_ptr - TAPS_A
                                          : new_ptr + BACK_A;

  assign rd_en  = (state == SEQ) && (cnt >= AW'(1)) && (cnt <= TAPS_A);
  assign rd_sum = {1'b0, start} + {1'b0, cnt} - 1'b1;
  assign rd_addr = (rd_sum >= DEP_W) ? AW'(rd_sum - DEP_W)
                                     : AW'(rd_sum);

  assign out_en = (state == SEQ) && (cnt >= AW'(2));

  // write pointer and fill level; writes are taken in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr  <= '0;
      fill_cnt <= '0;
    end else if (wrt_smpl) begin
      new_ptr  <= (new_ptr == LAST) ? '0 : new_ptr + 1'b1;
      fill_cnt <= fill_nxt;
    end
  end

  // replay sequencer: latch window start, count the frame, one-cycle gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= 1'b0;
      start      <= '0;
      cnt        <= '0;
      sequencing <= 1'b0;
    end else begin
      if (trigger)
        pending <= 1'b1;
      else if (state == IDLE && pending)
        pending <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pending) begin
            start      <= start_calc;
            cnt        <= '0;
            sequencing <= 1'b1;
            state      <= SEQ;
          end
        end
        SEQ: begin
          cnt <= cnt + 1'b1;
          if (cnt == END_A) begin
            sequencing <= 1'b0;
            state      <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          sequencing <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  dp_ram_16x2 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk (clk),
    .we  (wrt_smpl),
    .wa  (new_ptr),
    .wl  (lft_smpl),
    .wr  (rght_smpl),
    .re  (rd_en),
    .ra  (rd_addr),
    .rl  (q_l),
    .rr  (q_r)
  );

  assign lft_out  = out_en ? q_l : 16'd0;
  assign rght_out = out_en ? q_r : 16'd0;

endmodule

// File: tb/tb_stereo_sample_queue.sv
// Directed bench for stereo_sample_queue.
// Frames are captured by a monitor and checked against write history.
module tb_stereo_sample_queue;

  localparam int TAPS = 1021;
  localparam int FLEN = TAPS + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt_smpl = 1'b0;
  logic [15:0] lft_smpl = '0;
  logic [15:0] rght_smpl = '0;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] hist_l [$];
  logic [15:0] hist_r [$];

  logic [15:0] cur_l [FLEN];
  logic [15:0] cur_r [FLEN];
  logic [15:0] last_l [FLEN];
  logic [15:0] last_r [FLEN];
  int idx = 0;
  int last_len = 0;
  int frame_cnt = 0;
  int rises = 0;
  int low_cnt = 0;
  int gap_len = 0;
  logic prev_seq = 1'b0;

  stereo_sample_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 0;
      prev_seq <= 1'b0;
    end else begin
      if (sequencing) begin
        if (!prev_seq) begin
          rises   <= rises + 1;
          gap_len <= low_cnt;
          cur_l[0] <= lft_out;
          cur_r[0] <= rght_out;
          idx     <= 1;
        end else begin
          if (idx < FLEN) begin
            cur_l[idx] <= lft_out;
            cur_r[idx] <= rght_out;
          end
          idx <= idx + 1;
        end
      end else begin
        if (prev_seq) begin
          last_l    <= cur_l;
          last_r    <= cur_r;
          last_len  <= idx;
          frame_cnt <= frame_cnt + 1;
          low_cnt   <= 1;
        end else begin
          low_cnt <= low_cnt + 1;
        end
      end
      prev_seq <= sequencing;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] l, input logic [15:0] r);
    wrt_smpl  = 1'b1;
    lft_smpl  = l;
    rght_smpl = r;
    hist_l.push_back(l);
    hist_r.push_back(r);
    @(negedge clk);
    wrt_smpl = 1'b0;
  endtask

  task automatic wri(input int i);
    wr(16'(i), 16'hFFFF - 16'(i));
  endtask

  task automatic wait_frames(input string tag, input int target,
                             input int budget);
    int n = 0;
    while (frame_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(frame_cnt >= target), 32'd1);
  endtask

  task automatic wait_rise(input string tag);
    int n = 0;
    while (!sequencing && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sequencing), 32'd1);
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    int lo = 0;
    while (lo < 8 && n < 20000) begin
      @(negedge clk);
      lo = sequencing ? 0 : lo + 1;
      n++;
    end
    chk(tag, 32'(lo >= 8), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int newest);
    int bad = 0;
    int b = newest - TAPS + 1;
    chk({tag, "_len"}, 32'(last_len), 32'(FLEN));
    if (last_l[0] !== 16'd0 || last_r[0] !== 16'd0) bad++;
    if (last_l[1] !== 16'd0 || last_r[1] !== 16'd0) bad++;
    for (int k = 0; k < TAPS; k++) begin
      if (last_l[k+2] !== hist_l[b+k] || last_r[k+2] !== hist_r[b+k])
        bad++;
    end
    chk({tag, "_first"}, 32'(last_l[2]), 32'(hist_l[b]));
    chk({tag, "_newest"}, 32'(last_l[FLEN-1]), 32'(hist_l[newest]));
    chk({tag, "_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int f0;
    int r0;
    @(negedge clk);
    chk("rst_seq", 32'(sequencing), 32'd0);
    chk("rst_lft", 32'(lft_out), 32'd0);
    chk("rst_rght", 32'(rght_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < TAPS - 1; i++) wri(i);
    repeat (5) @(negedge clk);
    chk("t1_no_trigger", 32'(rises), 32'd0);

    wri(TAPS - 1);
    wait_frames("t2_timeout", 1, 2000);
    check_frame("t2", TAPS - 1);
    chk("t2_lft_k0", 32'(last_l[2]), 32'd0);
    chk("t2_lft_k1020", 32'(last_l[FLEN-1]), 32'd1020);

    for (int i = TAPS; i < 1600; i++) wri(i);
    wait_quiet("t3_quiet");
    check_frame("t3", 1599);
    chk("t3_lft_first", 32'(last_l[2]), 32'd579);

    f0 = frame_cnt;
    wri(1600);
    wait_rise("t4_rise");
    repeat (500) @(negedge clk);
    wr(16'h7FFF, 16'h8000);
    wait_frames("t4_cur_timeout", f0 + 1, 2000);
    check_frame("t4_cur", 1600);
    wait_frames("t4_new_timeout", f0 + 2, 2000);
    chk("t4_gap", 32'(gap_len >= 1 && gap_len <= 2), 32'd1);
    check_frame("t4_new", 1601);
    chk("t4_last_7fff", 32'(last_l[FLEN-1]), 32'h7FFF);

    wait_quiet("t5_pre_quiet");
    f0 = frame_cnt;
    wri(1602);
    wait_rise("t5_rise");
    for (int j = 0; j < 3; j++) begin
      repeat (100) @(negedge clk);
      wri(1603 + j);
    end
    wait_frames("t5_timeout", f0 + 2, 4000);
    wait_quiet("t5_quiet");
    chk("t5_one_extra", 32'(frame_cnt), 32'(f0 + 2));
    check_frame("t5", 1605);

    wri(1606);
    wait_rise("t6_rise");
    repeat (300) @(negedge clk);
    chk("t6_pre_lft", 32'(lft_out), 32'(hist_l[1606 - TAPS + 1 + 298]));
    #3 rst_n = 1'b0;
    #1;
    chk("t6_seq_async", 32'(sequencing), 32'd0);
    chk("t6_lft_async", 32'(lft_out), 32'd0);
    chk("t6_rght_async", 32'(rght_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    r0 = rises;
    f0 = frame_cnt;
    for (int i = 0; i < TAPS - 1; i++) wri(2000 + i);
    repeat (5) @(negedge clk);
    chk("t6_no_trigger", 32'(rises), 32'(r0));
    wri(2000 + TAPS - 1);
    wait_frames("t6_refill_timeout", f0 + 1, 2000);
    check_frame("t6_refill", hist_l.size() - 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
